sw_do_lut: RTL and testbench

Single switch stage of an arbiter-style PUF delay chain, built as one dual-output 6-input LUT (LUT6_2 model). It passes the top/bottom race signals straight through (challenge bit `c` = 0) or crossed (`c` = 1), on a purely combinational path. A clocked capture stage samples the switch outputs for debug and readback without loading or delaying the race path. Many instances are chained, one per challenge bit, ahead of the arbiter.

---
 rtl/sw_do_lut.sv | 56 +++++
 tb/tb_sw_do_lut.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_do_lut.sv
// sw_do_lut: one switch stage of an arbiter PUF delay chain.
// A single dual-output LUT (LUT6_2 behaviour) routes the top/bottom race
// signals straight (c = 0) or crossed (c = 1) with no clock on the race path.
// A separate capture register samples the switch outputs for readback only.
module sw_do_lut #(
  parameter logic [63:0] INIT = 64'hCACACACA_ACACACAC
) (
  input  logic clk,
  input  logic rst,
  input  logic iT,
  input  logic iB,
  input  logic c,
  input  logic vcc,
  output logic oT,
  output logic oB,
  output logic oT_q,
  output logic oB_q
);

  localparam int unsigned IDX_W  = 6;
  localparam int unsigned HALF_W = 5;

  // LUT address {I5, I4, I3, I2, I1, I0}; I3/I4 are unused pins tied low.
  logic [IDX_W-1:0]  lut_idx;
  logic [HALF_W-1:0] lut_idx_lo;

  // Kept as one cell so the top and bottom race paths stay symmetric.
  (* keep = "true", dont_touch = "true" *) logic lut_o5;
  (* keep = "true", dont_touch = "true" *) logic lut_o6;

  assign lut_idx    = {vcc, 1'b0, 1'b0, c, iB, iT};
  assign lut_idx_lo = lut_idx[HALF_W-1:0];

  // Generic LUT6_2 read: O5 from the lower half, O6 from the full address.
  always_comb begin
    lut_o5 = 1'b0;
    lut_o6 = 1'b0;
    lut_o5 = INIT[{1'b0, lut_idx_lo}];
    lut_o6 = INIT[lut_idx];
  end

  assign oT = lut_o6;
  assign oB = lut_o5;

  // Debug capture of the switch outputs; never feeds back into the race path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oT_q <= 1'b0;
      oB_q <= 1'b0;
    end else begin
      oT_q <= lut_o6;
      oB_q <= lut_o5;
    end
  end

endmodule

// File: tb/tb_sw_do_lut.sv
// Bench for sw_do_lut: default, all-zero and custom INIT instances driven
// from shared inputs and compared against a behavioural switch/LUT model.
module tb_sw_do_lut;

  localparam logic [63:0] CUST_INIT = 64'h0123_4567_89AB_CDEF;

  logic clk, rst, iT, iB, c, vcc;
  logic d_oT, d_oB, d_oT_q, d_oB_q;
  logic z_oT, z_oB, z_oT_q, z_oB_q;
  logic k_oT, k_oB, k_oT_q, k_oB_q;

  int vec_cnt;
  int err_cnt;
  int edge_cnt;

  sw_do_lut u_dut (
    .clk(clk), .rst(rst), .iT(iT), .iB(iB), .c(c), .vcc(vcc),
    .oT(d_oT), .oB(d_oB), .oT_q(d_oT_q), .oB_q(d_oB_q)
  );

  sw_do_lut #(.INIT(64'h0)) u_zero (
    .clk(clk), .rst(rst), .iT(iT), .iB(iB), .c(c), .vcc(vcc),
    .oT(z_oT), .oB(z_oB), .oT_q(z_oT_q), .oB_q(z_oB_q)
  );

  sw_do_lut #(.INIT(CUST_INIT)) u_cust (
    .clk(clk), .rst(rst), .iT(iT), .iB(iB), .c(c), .vcc(vcc),
    .oT(k_oT), .oB(k_oB), .oT_q(k_oT_q), .oB_q(k_oB_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every transition on the default-instance outputs (glitch watch).
  always @(d_oT or d_oB) edge_cnt++;

  // Switch behaviour of the default truth table: {top, bottom}.
  function automatic logic [1:0] ref_switch(input logic t, input logic b,
                                            input logic ch, input logic v);
    logic top, bot;
    bot = ch ? t : b;
    if (v) top = ch ? b : t;
    else   top = bot;
    return {top, bot};
  endfunction

  // Plain LUT6_2 read for an arbitrary truth table: {O6, O5}.
  function automatic logic [1:0] ref_lut(input logic [63:0] init, input logic t,
                                         input logic b, input logic ch, input logic v);
    int a;
    a = int'(ch) * 4 + int'(b) * 2 + int'(t);
    return {init[a + (v ? 32 : 0)], init[a]};
  endfunction

  task automatic drive(input logic t, input logic b, input logic ch, input logic v);
    iT = t; iB = b; c = ch; vcc = v;
  endtask

  task automatic chk_comb(input string name, input logic [1:0] exp);
    vec_cnt++;
    if ({d_oT, d_oB} !== exp) begin
      err_cnt++;
      $display("FAIL %s: iT=%b iB=%b c=%b vcc=%b got oT,oB=%b%b want %b%b",
               name, iT, iB, c, vcc, d_oT, d_oB, exp[1], exp[0]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    #3;
    vec_cnt++;
    if ({d_oT_q, d_oB_q, z_oT_q, z_oB_q, k_oT_q, k_oB_q} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset: got q=%b%b want 00", d_oT_q, d_oB_q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_straight;
    logic [1:0] tbl [3] = '{2'b00, 2'b10, 2'b01};
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i][1], tbl[i][0], 1'b0, 1'b1);
      #1;
      chk_comb("straight", tbl[i]);
    end
  endtask

  task automatic test_crossed;
    logic [1:0] tin [3] = '{2'b10, 2'b01, 2'b11};
    logic [1:0] tex [3] = '{2'b01, 2'b10, 2'b11};
    foreach (tin[i]) begin
      @(negedge clk);
      drive(tin[i][1], tin[i][0], 1'b1, 1'b1);
      #1;
      chk_comb("crossed", tex[i]);
    end
  endtask

  task automatic test_repeat;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    #1;
    chk_comb("repeat_first", 2'b10);
    edge_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      #10;
      drive(1'b0, 1'b1, 1'b1, 1'b1);
      chk_comb("repeat_hold", 2'b10);
    end
    vec_cnt++;
    if (edge_cnt !== 0) begin
      err_cnt++;
      $display("FAIL repeat_glitch: got %0d output edges want 0", edge_cnt);
    end
  endtask

  task automatic test_vcc_low;
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    chk_comb("vcc_low_01", 2'b11);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk_comb("vcc_low_10", 2'b00);
  endtask

  task automatic test_capture;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1);
    @(posedge clk); @(posedge clk);
    #1;
    vec_cnt++;
    if (d_oT_q !== 1'b0) begin
      err_cnt++;
      $display("FAIL capture_hold: got oT_q=%b want 0", d_oT_q);
    end
    vec_cnt++;
    if (d_oT !== 1'b1) begin
      err_cnt++;
      $display("FAIL capture_comb_in_rst: got oT=%b want 1", d_oT);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (d_oT_q !== 1'b0) begin
      err_cnt++;
      $display("FAIL capture_pre_edge: got oT_q=%b want 0", d_oT_q);
    end
    @(posedge clk);
    #1;
    vec_cnt++;
    if (d_oT_q !== 1'b1) begin
      err_cnt++;
      $display("FAIL capture_resume: got oT_q=%b want 1", d_oT_q);
    end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (d_oT_q !== 1'b0) begin
      err_cnt++;
      $display("FAIL capture_async_rst: got oT_q=%b want 0", d_oT_q);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_init_generic;
    logic [1:0] ez, ek;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      drive(n[0], n[1], n[2], n[3]);
      #1;
      ez = ref_lut(64'h0, iT, iB, c, vcc);
      ek = ref_lut(CUST_INIT, iT, iB, c, vcc);
      vec_cnt++;
      if ({z_oT, z_oB} !== ez || ez !== 2'b00) begin
        err_cnt++;
        $display("FAIL init_zero: n=%0d got %b%b want 00", n, z_oT, z_oB);
      end
      vec_cnt++;
      if ({k_oT, k_oB} !== ek) begin
        err_cnt++;
        $display("FAIL init_custom: n=%0d got %b%b want %b", n, k_oT, k_oB, ek);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0] ed, ek;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      #1;
      ed = ref_switch(iT, iB, c, vcc);
      ek = ref_lut(CUST_INIT, iT, iB, c, vcc);
      chk_comb("random_comb", ed);
      vec_cnt++;
      if ({k_oT, k_oB} !== ek) begin
        err_cnt++;
        $display("FAIL random_custom: got %b%b want %b", k_oT, k_oB, ek);
      end
      @(posedge clk);
      #1;
      vec_cnt++;
      if ({d_oT_q, d_oB_q, k_oT_q, k_oB_q, z_oT_q, z_oB_q} !== {ed, ek, 2'b00}) begin
        err_cnt++;
        $display("FAIL random_capture: got %b%b%b%b%b%b want %b%b00",
                 d_oT_q, d_oB_q, k_oT_q, k_oB_q, z_oT_q, z_oB_q, ed, ek);
      end
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    edge_cnt = 0;
    test_reset();
    test_straight();
    test_crossed();
    test_repeat();
    test_vcc_low();
    test_capture();
    test_init_generic();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
